mac_cluster: RTL and testbench
==============================

Name: mac_cluster

Overview:
- Four-lane reconfigurable multiply-accumulate cluster built from four 8-bit multiplier lanes.
- The lanes operate as four independent 8x8 MACs, two 16x16 MACs, or one 32x32 MAC.
- Each mode can be signed or unsigned, and accumulating or overwrite.
- Sits in the fabric's compute tile; configured through a wide cfg bus loaded on cset. Accumulator initial values travel on the same bus.

Parameters:
- MAC_CONF_WIDTH, 4, mode/control bits at cfg[3:0].
- MAC_MIN_WIDTH, 8, width of each A/B lane operand.
- MAC_MULT_WIDTH, 16, width of one lane product (2*MIN).
- MAC_ACC_WIDTH, 32, width of each output/accumulator slice (4*MIN).
- MAC_INT_WIDTH, 40, internal partial-sum width for carry handling (5*MIN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cset  in  1  config-set strobe: latch cfg, load accumulators, flush pipeline.
- en  in  1  clock enable for all state.
- A0..A3  in  MIN each  operand A lanes; lane 0 is least significant.
- B0..B3  in  MIN each  operand B lanes; lane 0 is least significant.
- cfg  in  4*ACC+CONF (132)  {init3,init2,init1,init0,ctrl[3:0]}.
- out0..out3  out  ACC each  accumulator slices; out0 is least significant.

Behaviour:
- Interface decided: reset rst, synchronous, active-high; clock clk. Priority per edge: rst > cset > en.
- ctrl[1:0] mode, from shared constants:
  - MAC_SINGLE=2'b00: lane i computes A_i*B_i into out_i.
  - MAC_DUAL=2'b01: {out1,out0} from {A1,A0}*{B1,B0}; {out3,out2} from {A3,A2}*{B3,B2}.
  - MAC_QUAD=2'b10: {out3..out0} from {A3..A0}*{B3..B0}.
  - 2'b11 reserved: outputs hold.
- ctrl[2]: 1 = accumulate (out <= product + out); 0 = overwrite (out <= product).
- ctrl[3]: 1 = two's-complement operands; 0 = unsigned.
- Width rules:
  - Product is the full 2N-bit result, sign- or zero-extended to the accumulator width of the mode (32/64/128).
  - Addition wraps modulo 2^width; no saturation, no overflow flag.
  - In dual/quad modes, carries propagate across slices.
- Reset: out0..out3=0, both pipeline stages=0, latched ctrl=0 (single, unsigned, overwrite).
- cset (rst=0), on the edge:
  - ctrl latched from cfg[3:0].
  - out_i <= init_i.
  - Both operand pipeline stages cleared to 0.
  - Mode changes only via cset.
- Pipeline, when en=1 and no rst/cset:
  - A/B captured into stage0 at edge k; stage0 moves to stage1 at edge k+1.
  - Outputs update from stage1 at edge k+2. Operands presented before edge k are visible on out after edge k+2 (3-register latency).
  - For two edges after cset, stage1 holds zeros: accumulate mode holds the init values; overwrite mode yields 0.
- en=0: all registers hold, including the pipeline.
- Outputs come directly from registers; there is no combinational input-to-output path.

Decomposition:
- Package/header mac_const: MAC_SINGLE/MAC_DUAL/MAC_QUAD encodings and ctrl bit indices (ACC_BIT=2, SIGNED_BIT=3).
- One sub-module, mac_mul8: 9x9 signed multiplier on sign/zero-extended 8-bit slices. Instantiate 16 cross-products, or 4 for single mode.
- Parent combines shifted partials with the sign-correction terms per mode using MAC_INT_WIDTH intermediates.

Test Plan:
- Single unsigned overwrite: cset ctrl=0000, then A0=200,B0=3, A1=255,B1=255 -> three edges later out0=600, out1=65025.
- Single signed overwrite: ctrl=1000, A0=0xFF,B0=0x02 -> out0=0xFFFFFFFE; A2=0x80,B2=0x80 -> out2=16384.
- Dual unsigned accumulate: ctrl=0101, init0=10, init1=0; one sample {A1,A0}=0x0100,{B1,B0}=0x0003, then zeros -> out0 10,10,778 then holds 778; out1=0.
- Quad signed overwrite: ctrl=1010, A=0xFFFFFFFF, B=5 -> out0=0xFFFFFFFB, out1..3=0xFFFFFFFF.
- Quad unsigned accumulate carry: init0=0xFFFFFFFF, A=1, B=1 -> out0=0, out1=1.
- Control edges: cset mid-stream -> pipeline flushed, out=init for 2 edges; en=0 -> outputs frozen; rst -> all outs 0 next edge.

Source files
------------

// File: rtl/mac_cluster_pkg.sv
// Shared constants for the reconfigurable MAC cluster: widths, mode
// encodings, control-bit positions and the lane grouping helper.
package mac_cluster_pkg;

  localparam int MAC_CONF_WIDTH = 4;   // ctrl bits at cfg[3:0]
  localparam int MAC_MIN_WIDTH  = 8;   // one operand lane
  localparam int MAC_MULT_WIDTH = 16;  // one lane product
  localparam int MAC_ACC_WIDTH  = 32;  // one output slice
  localparam int MAC_INT_WIDTH  = 40;  // 16x16 block partial sum with headroom
  localparam int MAC_LANES      = 4;

  // ctrl bit positions
  localparam int ACC_BIT    = 2;
  localparam int SIGNED_BIT = 3;

  typedef enum logic [1:0] {
    MAC_SINGLE = 2'b00,
    MAC_DUAL   = 2'b01,
    MAC_QUAD   = 2'b10,
    MAC_RSVD   = 2'b11
  } mac_mode_e;

  // True when a lane holds the most significant byte of its operand group,
  // i.e. the only byte that carries the sign in two's-complement mode.
  function automatic logic lane_is_top(input mac_mode_e mode, input int lane);
    logic top;
    top = 1'b0;
    case (mode)
      MAC_SINGLE: top = 1'b1;
      MAC_DUAL:   top = ((lane % 2) == 1);
      MAC_QUAD:   top = (lane == MAC_LANES - 1);
      default:    top = 1'b0;
    endcase
    return top;
  endfunction

endpackage

// File: rtl/mac_mul8.sv
// 9x9 signed multiplier on one 8-bit slice pair. The caller supplies the
// extension bit per operand: the slice MSB for a sign-carrying byte, zero
// otherwise, so one multiplier serves both signed and unsigned slices.
module mac_mul8
  import mac_cluster_pkg::*;
(
  input  logic [MAC_MIN_WIDTH-1:0]         a_i,
  input  logic [MAC_MIN_WIDTH-1:0]         b_i,
  input  logic                             a_ext_i,
  input  logic                             b_ext_i,
  output logic signed [MAC_MULT_WIDTH+1:0] p_o
);

  logic signed [MAC_MIN_WIDTH:0] a_s;
  logic signed [MAC_MIN_WIDTH:0] b_s;

  assign a_s = {a_ext_i, a_i};
  assign b_s = {b_ext_i, b_i};
  assign p_o = a_s * b_s;

endmodule

// File: rtl/mac_cluster.sv
// Four-lane reconfigurable multiply-accumulate cluster. Operands pass through
// two pipeline stages; the accumulator slices update from stage 1. The lanes
// act as four 8x8, two 16x16 or one 32x32 MAC, signed or unsigned,
// accumulating or overwriting. cset latches ctrl, loads the accumulators from
// cfg and flushes the operand pipeline.
module mac_cluster
  import mac_cluster_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cset,
  input  logic                                      en,
  input  logic [MAC_MIN_WIDTH-1:0]                  A0,
  input  logic [MAC_MIN_WIDTH-1:0]                  A1,
  input  logic [MAC_MIN_WIDTH-1:0]                  A2,
  input  logic [MAC_MIN_WIDTH-1:0]                  A3,
  input  logic [MAC_MIN_WIDTH-1:0]                  B0,
  input  logic [MAC_MIN_WIDTH-1:0]                  B1,
  input  logic [MAC_MIN_WIDTH-1:0]                  B2,
  input  logic [MAC_MIN_WIDTH-1:0]                  B3,
  input  logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] cfg,
  output logic [MAC_ACC_WIDTH-1:0]                  out0,
  output logic [MAC_ACC_WIDTH-1:0]                  out1,
  output logic [MAC_ACC_WIDTH-1:0]                  out2,
  output logic [MAC_ACC_WIDTH-1:0]                  out3
);

  localparam int OPW = MAC_LANES * MAC_MIN_WIDTH;  // 32-bit operand bus
  localparam int OUTW = MAC_LANES * MAC_ACC_WIDTH; // 128-bit accumulator

  // State
  logic [MAC_CONF_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [OPW-1:0]            a_s0_q, a_s0_d, b_s0_q, b_s0_d;
  logic [OPW-1:0]            a_s1_q, a_s1_d, b_s1_q, b_s1_d;
  logic [OUTW-1:0]           out_q, out_d;

  // Datapath
  mac_mode_e                              mode;
  logic [MAC_LANES-1:0]                   a_ext, b_ext;
  logic signed [MAC_MULT_WIDTH+1:0]       prod [MAC_LANES][MAC_LANES];
  logic signed [MAC_INT_WIDTH-1:0]        blk [2][2];
  logic signed [OUTW-1:0]                 quad_sum;
  logic signed [2*MAC_ACC_WIDTH-1:0]      dual_sum [2];
  logic signed [MAC_ACC_WIDTH-1:0]        single_sum [MAC_LANES];
  logic [OUTW-1:0]                        acc_base;
  logic [OUTW-1:0]                        mac_result;

  assign mode = mac_mode_e'(ctrl_q[1:0]);

  // Extension bits: only the top byte of each operand group is sign-carrying.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    for (int i = 0; i < MAC_LANES; i++) begin
      a_ext[i] = ctrl_q[SIGNED_BIT] & lane_is_top(mode, i) &
                 a_s1_q[i*MAC_MIN_WIDTH + MAC_MIN_WIDTH-1];
      b_ext[i] = ctrl_q[SIGNED_BIT] & lane_is_top(mode, i) &
                 b_s1_q[i*MAC_MIN_WIDTH + MAC_MIN_WIDTH-1];
    end
  end

  // All sixteen byte cross-products; single mode uses only the diagonal.
  for (genvar gi = 0; gi < MAC_LANES; gi++) begin : g_row
    for (genvar gj = 0; gj < MAC_LANES; gj++) begin : g_col
      mac_mul8 u_mul (
        .a_i     (a_s1_q[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH]),
        .b_i     (b_s1_q[gj*MAC_MIN_WIDTH +: MAC_MIN_WIDTH]),
        .a_ext_i (a_ext[gi]),
        .b_ext_i (b_ext[gj]),
        .p_o     (prod[gi][gj])
      );
    end
  end

  // Fold byte products into 16x16 block products. Because only the top byte
  // of a group is signed, plain sign-extended shifted sums give the exact
  // two's-complement product without separate correction terms.
  always_comb begin
    for (int bi = 0; bi < 2; bi++) begin
      for (int bj = 0; bj < 2; bj++) begin
        blk[bi][bj] = '0;
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            blk[bi][bj] = blk[bi][bj] +
              (MAC_INT_WIDTH'(prod[2*bi+i][2*bj+j]) <<< (MAC_MIN_WIDTH*(i+j)));
          end
        end
      end
    end
  end

  // Full-width products for each mode, sign/zero-extended to the group width.
  always_comb begin
    quad_sum = OUTW'(blk[0][0])
             + (OUTW'(blk[0][1]) <<< (2*MAC_MIN_WIDTH))
             + (OUTW'(blk[1][0]) <<< (2*MAC_MIN_WIDTH))
             + (OUTW'(blk[1][1]) <<< (4*MAC_MIN_WIDTH));
    for (int g = 0; g < 2; g++) begin
      dual_sum[g] = (2*MAC_ACC_WIDTH)'(blk[g][g]);
    end
    for (int k = 0; k < MAC_LANES; k++) begin
      single_sum[k] = MAC_ACC_WIDTH'(prod[k][k]);
    end
  end

  // Accumulate or overwrite per group; additions wrap, and in wide modes
  // carries ripple across slice boundaries. Reserved mode holds.
  always_comb begin
    acc_base   = ctrl_q[ACC_BIT] ? out_q : '0;
    mac_result = out_q;
    case (mode)
      MAC_SINGLE: begin
        for (int k = 0; k < MAC_LANES; k++) begin
          mac_result[k*MAC_ACC_WIDTH +: MAC_ACC_WIDTH] =
            single_sum[k] + acc_base[k*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
        end
      end
      MAC_DUAL: begin
        for (int g = 0; g < 2; g++) begin
          mac_result[g*2*MAC_ACC_WIDTH +: 2*MAC_ACC_WIDTH] =
            dual_sum[g] + acc_base[g*2*MAC_ACC_WIDTH +: 2*MAC_ACC_WIDTH];
        end
      end
      MAC_QUAD: mac_result = quad_sum + acc_base;
      default:  mac_result = out_q;
    endcase
  end

  // Next-state selection: cset has priority over en; reset is applied in the
  // register process.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    ctrl_d = ctrl_q;
    a_s0_d = a_s0_q;
    b_s0_d = b_s0_q;
    a_s1_d = a_s1_q;
    b_s1_d = b_s1_q;
    out_d  = out_q;
    if (cset) begin
      ctrl_d = cfg[MAC_CONF_WIDTH-1:0];
      a_s0_d = '0;
      b_s0_d = '0;
      a_s1_d = '0;
      b_s1_d = '0;
      out_d  = cfg[MAC_CONF_WIDTH +: OUTW];
    end else if (en) begin
      a_s0_d = {A3, A2, A1, A0};
      b_s0_d = {B3, B2, B1, B0};
      a_s1_d = a_s0_q;
      b_s1_d = b_s0_q;
      out_d  = mac_result;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ctrl_q <= '0;
      a_s0_q <= '0;
      b_s0_q <= '0;
      a_s1_q <= '0;
      b_s1_q <= '0;
      out_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      a_s0_q <= a_s0_d;
      b_s0_q <= b_s0_d;
      a_s1_q <= a_s1_d;
      b_s1_q <= b_s1_d;
      out_q  <= out_d;
    end
  end

  assign out0 = out_q[0*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
  assign out1 = out_q[1*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
  assign out2 = out_q[2*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
  assign out3 = out_q[3*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];

endmodule

// File: tb/tb_mac_cluster.sv
// Self-checking bench for mac_cluster: directed cases from the intended
// behaviour plus randomized traffic against an arithmetic reference model,
// compared through a scoreboard queue.
module tb_mac_cluster;

  logic         clk = 1'b0;
  logic         rst, cset, en;
  logic [31:0]  a_bus, b_bus;
  logic [131:0] cfg;
  logic [31:0]  out0, out1, out2, out3;
  logic [127:0] dut_out;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q [$];

  // Reference model state
  logic [3:0]   m_ctrl;
  logic [127:0] m_out;
  logic [63:0]  m_pipe [$];   // front = oldest sample, {A,B}

  always #5 clk = ~clk;

  mac_cluster dut (
    .clk  (clk),
    .rst  (rst),
    .cset (cset),
    .en   (en),
    .A0   (a_bus[7:0]),
    .A1   (a_bus[15:8]),
    .A2   (a_bus[23:16]),
    .A3   (a_bus[31:24]),
    .B0   (b_bus[7:0]),
    .B1   (b_bus[15:8]),
    .B2   (b_bus[23:16]),
    .B3   (b_bus[31:24]),
    .cfg  (cfg),
    .out0 (out0),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  assign dut_out = {out3, out2, out1, out0};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Interpret an nb-bit field as signed or unsigned, as a 128-bit value.
  function automatic logic [127:0] ext(input logic [31:0] v, input int nb, input bit sg);
    logic [127:0] r;
    r = 128'(v) & ((128'd1 << nb) - 128'd1);
    if (sg && r[nb-1]) r = r - (128'd1 << nb);
    return r;
  endfunction

  // One accumulator update: groups of n bytes multiply into 32n-bit slices.
  function automatic logic [127:0] mac_model(input logic [3:0] ctrl, input logic [127:0] old,
                                             input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [127:0] mask, av, bv, p, go, nv, res;
    case (ctrl[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: return old;
    endcase
    mask = (n == 4) ? {128{1'b1}} : ((128'd1 << (32*n)) - 128'd1);
    res  = '0;
    for (int g = 0; g < 4/n; g++) begin
      av  = ext(a >> (8*n*g), 8*n, ctrl[3]);
      bv  = ext(b >> (8*n*g), 8*n, ctrl[3]);
      p   = av * bv;
      go  = (old >> (32*n*g)) & mask;
      nv  = ((ctrl[2] ? go : 128'd0) + p) & mask;
      res = res | (nv << (32*n*g));
    end
    return res;
  endfunction

  // Drive one cycle, advance the model, push the post-edge expectation.
  task automatic step(input logic r, input logic c, input logic e,
                      input logic [31:0] a, input logic [31:0] b, input logic [131:0] cf);
    logic [63:0] oldest;
    rst = r; cset = c; en = e; a_bus = a; b_bus = b; cfg = cf;
    if (r) begin
      m_ctrl = '0; m_out = '0;
      m_pipe.delete(); m_pipe.push_back(64'd0); m_pipe.push_back(64'd0);
    end else if (c) begin
      m_ctrl = cf[3:0]; m_out = cf[131:4];
      m_pipe.delete(); m_pipe.push_back(64'd0); m_pipe.push_back(64'd0);
    end else if (e) begin
      oldest = m_pipe.pop_front();
      m_out  = mac_model(m_ctrl, m_out, oldest[63:32], oldest[31:0]);
      m_pipe.push_back({a, b});
    end
    @(posedge clk);
    exp_q.push_back(m_out);
    #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b0, 1'b1, a, b, '0);
  endtask

  task automatic cfgset(input logic [3:0] ctrl, input logic [127:0] init);
    step(1'b0, 1'b1, 1'b1, $urandom, $urandom, {init, ctrl});
  endtask

  // Scoreboard monitor: one expectation per clock, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("scoreboard", dut_out, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] init_v;
    logic [31:0]  ra, rb;
    logic         r, c, e;

    rst = 1'b1; cset = 1'b0; en = 1'b0; a_bus = '0; b_bus = '0; cfg = '0;

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    check("reset", dut_out, 128'd0);

    // Single unsigned overwrite
    cfgset(4'b0000, 128'd0);
    op({8'd0, 8'd0, 8'd255, 8'd200}, {8'd0, 8'd0, 8'd255, 8'd3});
    op(32'd0, 32'd0);
    op(32'd0, 32'd0);
    check("single_unsigned", dut_out, {32'd0, 32'd0, 32'd65025, 32'd600});

    // Single signed overwrite
    cfgset(4'b1000, 128'd0);
    op(32'h0080_00FF, 32'h0080_0002);
    op(32'd0, 32'd0);
    op(32'd0, 32'd0);
    check("single_signed", dut_out, {32'd0, 32'd16384, 32'd0, 32'hFFFF_FFFE});

    // Dual unsigned accumulate
    cfgset(4'b0101, {96'd0, 32'd10});
    op(32'h0000_0100, 32'h0000_0003);
    check("dual_acc_e1", dut_out, {96'd0, 32'd10});
    op(32'd0, 32'd0);
    check("dual_acc_e2", dut_out, {96'd0, 32'd10});
    op(32'd0, 32'd0);
    check("dual_acc_e3", dut_out, {96'd0, 32'd778});
    op(32'd0, 32'd0);
    check("dual_acc_hold", dut_out, {96'd0, 32'd778});

    // Quad signed overwrite
    cfgset(4'b1010, 128'd0);
    op(32'hFFFF_FFFF, 32'd5);
    op(32'd0, 32'd0);
    op(32'd0, 32'd0);
    check("quad_signed", dut_out, {{3{32'hFFFF_FFFF}}, 32'hFFFF_FFFB});

    // Quad unsigned accumulate, carry across slice 0 -> 1
    cfgset(4'b0110, {96'd0, 32'hFFFF_FFFF});
    op(32'd1, 32'd1);
    op(32'd0, 32'd0);
    op(32'd0, 32'd0);
    check("quad_carry", dut_out, {64'd0, 32'd1, 32'd0});

    // cset mid-stream flushes the pipeline; accumulate holds the init values
    cfgset(4'b0100, 128'd0);
    for (int i = 0; i < 3; i++) op($urandom, $urandom);
    init_v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    cfgset(4'b0100, init_v);
    op($urandom, $urandom);
    check("flush_e1", dut_out, init_v);
    op($urandom, $urandom);
    check("flush_e2", dut_out, init_v);

    // en=0 freezes everything
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom, 4'($urandom)});
      check("freeze", dut_out, init_v);
    end

    // Reset mid-stream clears outputs on the next edge
    op($urandom, $urandom);
    op($urandom, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom, 4'($urandom)});
    check("reset_mid", dut_out, 128'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 9) != 0);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'h8080_8080;
      step(r, c, e, ra, rb, {$urandom, $urandom, $urandom, $urandom, 4'($urandom)});
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
